// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl
// Fades the three RGB LED channels toward the color word delivered by the
// UART receive stage. Each color bit selects a target duty of MAX_DUTY or 0.
// On every prescaler terminal count, each duty steps one unit toward its
// target. The duties drive a shared free-running PWM counter.
//
// Ports:
//   clk           system clock; all logic runs on the rising edge
//   rst_n         asynchronous active-low reset
//   color_in      color word: bit0 red, bit1 green, bit2 blue
//   color_valid   level qualifier; color_in is captured on every edge it is high
//   led_r/g/b     registered PWM pins, polarity set by LED_ACTIVE_LOW
//   busy          high while any duty differs from its target
//   current_color last accepted color word
//
// State | meaning
// IDLE  | every duty equals its target
// FADE  | at least one duty is still stepping toward its target
module rgb_fade_ctrl #(
  parameter int PWM_BITS       = 8,
  parameter int MAX_DUTY       = 255,
  parameter int STEP_CYCLES    = 27000,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] color_in,
  input  logic       color_valid,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy,
  output logic [2:0] current_color
);

  localparam int                   PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX = PWM_BITS'(MAX_DUTY);
  localparam logic                 LED_OFF  = (LED_ACTIVE_LOW != 0);

  typedef enum logic {IDLE, FADE} state_t;

  state_t                     state_q, state_d;
  logic [PRE_W-1:0]           pre_cnt;
  logic                       step_tick;
  logic [PWM_BITS-1:0]        pwm_cnt;
  logic [2:0][PWM_BITS-1:0]   duty, duty_nxt, target;
  logic                       mismatch;

  assign step_tick = (pre_cnt == PRE_LAST);

  // Targets come from the registered color, so a capture on a step_tick
  // edge still steps toward the previous targets.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      target[i] = current_color[i] ? DUTY_MAX : '0;
    end
  end

  assign mismatch = (duty != target);

  always_comb begin
    duty_nxt = duty;
    if (step_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (duty[i] < target[i]) begin
          duty_nxt[i] = duty[i] + 1'b1;
        end else if (duty[i] > target[i]) begin
          duty_nxt[i] = duty[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (step_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt       <= '0;
      duty          <= '0;
      current_color <= 3'b000;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      duty    <= duty_nxt;
      if (color_valid) begin
        current_color <= color_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mismatch)  state_d = FADE;
      FADE:    if (!mismatch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == FADE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= LED_OFF;
      led_g <= LED_OFF;
      led_b <= LED_OFF;
    end else begin
      led_r <= (duty[0] > pwm_cnt) ^ LED_OFF;
      led_g <= (duty[1] > pwm_cnt) ^ LED_OFF;
      led_b <= (duty[2] > pwm_cnt) ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Testbench for rgb_fade_ctrl with a small configuration (4-bit PWM,
// MAX_DUTY 15, 4-cycle steps, active-low LEDs). A reference model predicts
// the outputs after every clock edge and queues them. A separate monitor
// pops one entry on each falling edge and compares it with the pins.
module tb_rgb_fade_ctrl;

  localparam int PB = 4;
  localparam int M  = 15;
  localparam int S  = 4;
  localparam int AL = 1;
  localparam int P  = 1 << PB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] color_in = 3'b000;
  logic       color_valid = 1'b0;
  logic       led_r, led_g, led_b, busy;
  logic [2:0] current_color;

  always #5 clk = ~clk;

  rgb_fade_ctrl #(
    .PWM_BITS(PB), .MAX_DUTY(M), .STEP_CYCLES(S), .LED_ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .color_valid(color_valid),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy),
    .current_color(current_color)
  );

  typedef struct packed {
    logic       r, g, b, bsy;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: duty levels as integers and elapsed edges since reset.
  int   mdl_duty[3];
  int   mdl_color;
  int   mdl_k;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tgt(input int ch);
    return ((mdl_color >> ch) & 1) ? M : 0;
  endfunction

  function automatic bit mdl_idle();
    for (int ch = 0; ch < 3; ch++) if (mdl_duty[ch] != tgt(ch)) return 0;
    return 1;
  endfunction

  task automatic mdl_reset();
    for (int ch = 0; ch < 3; ch++) mdl_duty[ch] = 0;
    mdl_color = 0;
    mdl_k     = 0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, then queue the
  // outputs the model predicts for that edge.
  task automatic cycle(input logic v, input logic [2:0] c);
    exp_t e;
    bit   on[3];
    bit   any_diff;
    color_valid = v;
    color_in    = c;
    @(posedge clk);
    #1;
    any_diff = 0;
    for (int ch = 0; ch < 3; ch++) begin
      on[ch] = (mdl_duty[ch] > (mdl_k % P));
      if (mdl_duty[ch] != tgt(ch)) any_diff = 1;
    end
    if ((mdl_k % S) == S - 1) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (mdl_duty[ch] < tgt(ch))      mdl_duty[ch]++;
        else if (mdl_duty[ch] > tgt(ch)) mdl_duty[ch]--;
      end
    end
    if (v) mdl_color = c;
    e.r   = on[0] ^ AL[0];
    e.g   = on[1] ^ AL[0];
    e.b   = on[2] ^ AL[0];
    e.bsy = any_diff;
    e.col = 3'(mdl_color);
    exp_q.push_back(e);
    mdl_k++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'b000);
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 400 && !mdl_idle(); i++) cycle(1'b0, 3'b000);
    idle_cycles(2);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_leds"}, {led_r, led_g, led_b}, 3'b111);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_color"}, current_color, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("led_r", led_r, e.r);
      chk("led_g", led_g, e.g);
      chk("led_b", led_b, e.b);
      chk("busy", busy, e.bsy);
      chk("current_color", current_color, e.col);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_low, g_high;
    mdl_reset();

    // Reset values, visible before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(100);

    // Red fade-in, then the steady PWM pattern at full duty.
    cycle(1'b1, 3'b001);
    wait_model_idle();
    r_low = 0;
    g_high = 0;
    for (int i = 0; i < P; i++) begin
      cycle(1'b0, 3'b000);
      if (led_r == 1'b0) r_low++;
      if (led_g == 1'b1) g_high++;
    end
    chk("red_low_per_period", r_low, 15);
    chk("green_off_per_period", g_high, 16);

    // Back to black, then retarget a fresh red fade at duty 7.
    cycle(1'b1, 3'b000);
    wait_model_idle();
    cycle(1'b1, 3'b001);
    for (int i = 0; i < 200 && mdl_duty[0] != 7; i++) cycle(1'b0, 3'b000);
    chk("red_reached_7", mdl_duty[0], 7);
    cycle(1'b1, 3'b010);
    wait_model_idle();

    // Idempotent resend while idle at 101.
    cycle(1'b1, 3'b101);
    wait_model_idle();
    for (int i = 0; i < 20; i++) cycle(1'b1, 3'b101);

    // Capture landing on a step_tick edge.
    cycle(1'b1, 3'b000);
    wait_model_idle();
    while ((mdl_k % S) != S - 1) cycle(1'b0, 3'b000);
    cycle(1'b1, 3'b100);
    idle_cycles(12);
    wait_model_idle();

    // Reset in the middle of a fade.
    cycle(1'b1, 3'b111);
    idle_cycles(20);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_fade_reset");
    mdl_reset();
    color_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(30);

    // Randomized color traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
    end
    wait_model_idle();

    @(negedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
